reg_file_ctrl: RTL

Command-driven initiator for the 16-entry register file (`regfile_block`). It accepts a byte stream from the serial receive path, decodes write and read commands, and drives the register file's `WrEn`/`RdEn`/`Address`/`WrData` port. For reads, it captures `RdData` on `RdData_Valid` and forwards the byte to the serial transmit path with a valid/busy handshake.

---
 rtl/reg_file_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/reg_file_ctrl.sv
// Byte-command front end for the 16-entry register file: decodes write/read
// commands from the receive stream and returns read data to the transmitter.
module reg_file_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_TIMEOUT = 4
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_Busy,
  output logic                  CMD_ERR
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [DATA_WIDTH-1:0] OP_WR = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD = DATA_WIDTH'(8'hBB);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_SEND
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      TX_D_VLD  <= 1'b0;
      CMD_ERR   <= 1'b0;
      Address   <= '0;
      WrData    <= '0;
      TX_P_DATA <= '0;
    end else begin
      WrEn     <= 1'b0;
      RdEn     <= 1'b0;
      TX_D_VLD <= 1'b0;
      CMD_ERR  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA == OP_WR) begin
              state_reg <= WR_ADDR;
            end else if (RX_P_DATA == OP_RD) begin
              state_reg <= RD_ADDR;
            end else begin
              CMD_ERR <= 1'b1;
            end
          end
        end
        WR_ADDR: begin
          if (RX_D_VLD) begin
            Address   <= RX_P_DATA[ADDR_WIDTH-1:0];
            state_reg <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (RX_D_VLD) begin
            WrData    <= RX_P_DATA;
            WrEn      <= 1'b1;
            state_reg <= IDLE;
          end
        end
        RD_ADDR: begin
          if (RX_D_VLD) begin
            Address   <= RX_P_DATA[ADDR_WIDTH-1:0];
            RdEn      <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // cnt_reg==0 marks the RdEn cycle; the response window is counts 1..RD_TIMEOUT
          if (cnt_reg == '0) begin
            cnt_reg <= CNT_W'(1);
          end else if (RdData_Valid) begin
            TX_P_DATA <= RdData;
            cnt_reg   <= '0;
            state_reg <= TX_SEND;
          end else if (cnt_reg == CNT_W'(RD_TIMEOUT)) begin
            CMD_ERR   <= 1'b1;
            cnt_reg   <= '0;
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        TX_SEND: begin
          if (!TX_Busy) begin
            TX_D_VLD  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
